// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, default sizes and peripheral state encoding.
package spi_pkg;

    // Mode 0: sclk idles low, data sampled on the rising edge.
    localparam int unsigned SPI_CPOL          = 0;
    localparam int unsigned SPI_CPHA          = 0;
    localparam int unsigned SPI_DEFAULT_WIDTH = 8;
    localparam int unsigned SPI_DEFAULT_SYNC  = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer followed by one edge-detect flop.
// Ports:
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_d            : asynchronous input
//   o_level        : synchronized level (last synchronizer stage)
//   o_rise_c       : combinational one-cycle pulse on a synchronized rising edge
//   o_fall_c       : combinational one-cycle pulse on a synchronized falling edge
module spi_sync_edge #(
    parameter int unsigned N        = 2,
    parameter logic        IDLE_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [N-1:0] r_sync;
    logic         r_prev;

    // Shift chain; reset to the line's idle level so reset release creates no edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {N{IDLE_VAL}};
            r_prev <= IDLE_VAL;
        end else begin
            r_sync <= (r_sync << 1) | N'(i_d);
            r_prev <= r_sync[N-1];
        end
    end

    assign o_level  = r_sync[N-1];
    assign o_rise_c = r_sync[N-1] & ~r_prev;
    assign o_fall_c = ~r_sync[N-1] & r_prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 peripheral with a one-word transmit holding register.
// Ports:
//   i_clk, i_rst_n          : system clock, async active-low reset
//   i_sclk, i_cs_n, i_mosi  : external SPI lines (asynchronous)
//   o_miso, o_miso_oe       : serial out and its output enable
//   i_tx_data/i_tx_valid    : word offered to the holding register
//   o_tx_ready              : holding register empty
//   o_rx_data/o_rx_valid    : last received word and its update pulse
//   o_tx_underrun           : a load found the holding register empty
//   o_frame_error           : cs_n rose in the middle of a word
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = SPI_DEFAULT_SYNC
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_tx_underrun,
    output logic             o_frame_error
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.N(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sclk),
        .o_level(w_sclk_level_unused), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
    );
    spi_sync_edge #(.N(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cs_n),
        .o_level(w_cs_level), .o_rise_c(w_cs_rise), .o_fall_c(w_cs_fall)
    );
    spi_sync_edge #(.N(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_mosi),
        .o_level(w_mosi), .o_rise_c(w_mosi_rise_unused), .o_fall_c(w_mosi_fall_unused)
    );

    spi_state_e       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift_rx, r_shift_tx, r_hold, r_rx_data;
    logic             r_hold_empty, r_load_pend, r_rx_pend;
    logic             r_rx_valid, r_tx_underrun, r_frame_error;

    logic w_enter, w_exit, w_sample, w_fall, w_load, w_shift, w_ferr, w_word_done;

    assign w_word_done = (r_cnt == CNT_W'(WIDTH));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_cs_fall) w_state_next = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_rise) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Control decode; a cs_n rise masks any coincident sclk edge.
    always_comb begin
        w_enter  = 1'b0;
        w_exit   = 1'b0;
        w_sample = 1'b0;
        w_fall   = 1'b0;
        w_ferr   = 1'b0;
        case (r_state)
            ST_IDLE: w_enter = w_cs_fall;
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_exit = 1'b1;
                    w_ferr = (r_cnt != '0) && !w_word_done;
                end else begin
                    w_sample = w_sclk_rise;
                    w_fall   = w_sclk_fall;
                end
            end
            default: ;
        endcase
        // The first fall after a completed word reloads instead of shifting.
        w_load  = w_enter | (w_fall & r_load_pend);
        w_shift = w_fall & ~r_load_pend;
    end

    // Receive path: bit counter, shift register and word delivery.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_shift_rx  <= '0;
            r_rx_data   <= '0;
            r_rx_pend   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_load_pend <= 1'b0;
        end else begin
            r_rx_pend  <= 1'b0;
            r_rx_valid <= r_rx_pend;
            if (w_word_done) begin
                r_cnt     <= '0;
                r_rx_data <= r_shift_rx;
                r_rx_pend <= 1'b1;
            end else if (w_enter || w_exit) begin
                r_cnt <= '0;
            end else if (w_sample) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_sample) r_shift_rx <= (r_shift_rx << 1) | WIDTH'(w_mosi);
            if (w_enter || w_exit)  r_load_pend <= 1'b0;
            else if (w_word_done)   r_load_pend <= 1'b1;
            else if (w_load)        r_load_pend <= 1'b0;
        end
    end

    // Transmit path: holding register and output shifter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold        <= '0;
            r_hold_empty  <= 1'b1;
            r_shift_tx    <= '0;
            r_tx_underrun <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_tx_underrun <= w_load & r_hold_empty;
            r_frame_error <= w_ferr;
            if (w_load)       r_shift_tx <= r_hold_empty ? '0 : r_hold;
            else if (w_shift) r_shift_tx <= r_shift_tx << 1;
            // An accept can only happen when empty, so a coincident load underruns first.
            if (i_tx_valid && r_hold_empty) begin
                r_hold       <= i_tx_data;
                r_hold_empty <= 1'b0;
            end else if (w_load && !r_hold_empty) begin
                r_hold_empty <= 1'b1;
            end
        end
    end

    assign o_miso        = (r_state == ST_ACTIVE) & r_shift_tx[WIDTH-1];
    assign o_miso_oe     = ~w_cs_level;
    assign o_tx_ready    = r_hold_empty;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_tx_underrun;
    assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: a driver plays SPI master and pushes expected
// received words; a monitor pops them on every rx_valid and checks data and latency.
module tb_spi_peripheral;

    localparam int unsigned W    = 8;
    localparam int unsigned NS   = 2;
    localparam int unsigned HALF = 8;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_error;
    logic [W-1:0] rx_data;

    spi_peripheral #(.WIDTH(W), .SYNC_STAGES(NS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .o_miso_oe(miso_oe), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .o_tx_underrun(tx_underrun), .o_frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] data;
        int unsigned  rise_cyc;
    } rx_exp_t;
    rx_exp_t rxq[$];

    // Reference model of the transmit side and the expected pulse counts.
    logic         hold_full = 1'b0;
    logic [W-1:0] hold_val  = '0;
    logic [W-1:0] cur_tx    = '0;
    int obs_und = 0, obs_ferr = 0, exp_und = 0, exp_ferr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: count pulses and score every received word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_underrun) obs_und++;
            if (frame_error) obs_ferr++;
            if (rx_valid) begin
                if (rxq.size() == 0) begin
                    chk("rx_valid_unexpected", 32'(rx_valid), 32'd0);
                end else begin
                    rx_exp_t e;
                    e = rxq.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.data));
                    chk("rx_latency", cyc - e.rise_cyc, NS + 2);
                end
            end
        end
    end

    // A word load: take the holding register, or underrun with zeros.
    task automatic model_load();
        if (hold_full) begin
            cur_tx    = hold_val;
            hold_full = 1'b0;
        end else begin
            cur_tx = '0;
            exp_und++;
        end
    endtask

    task automatic write_tx(input logic [W-1:0] v);
        chk("tx_ready_before", 32'(tx_ready), 32'd1);
        tx_data  = v;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid  = 1'b0;
        hold_full = 1'b1;
        hold_val  = v;
        chk("tx_ready_after", 32'(tx_ready), 32'd0);
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        model_load();
        chk("miso_oe_active", 32'(miso_oe), 32'd1);
    endtask

    task automatic end_frame(input bit partial);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        if (partial) exp_ferr++;
        chk("miso_oe_idle", 32'(miso_oe), 32'd0);
        chk("miso_idle", 32'(miso), 32'd0);
    endtask

    // Clock out the top n bits of mo; miso is checked just before each rise.
    task automatic spi_bits(input logic [W-1:0] mo, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = mo[W-1-i];
            repeat (HALF) @(negedge clk);
            chk("miso_bit", 32'(miso), 32'(cur_tx[W-1-i]));
            sclk = 1'b1;
            if (i == W - 1) rxq.push_back('{mo, cyc + 1});
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (n == W) model_load();
    endtask

    task automatic check_counts();
        chk("underrun_count", 32'(obs_und), 32'(exp_und));
        chk("frame_error_count", 32'(obs_ferr), 32'(exp_ferr));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_underrun", 32'(tx_underrun), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        hold_full = 1'b0;
        rst_n     = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Single word, preloaded 0xA5, receive 0x3C.
        write_tx(8'hA5);
        start_frame();
        spi_bits(8'h3C, W);
        end_frame(1'b0);
        check_counts();

        // Back-to-back words with a refill after the first load.
        write_tx(8'hA5);
        start_frame();
        write_tx(8'h80);
        spi_bits(8'h01, W);
        spi_bits(8'hFF, W);
        end_frame(1'b0);
        check_counts();

        // Nothing written: underrun at cs_n fall, miso stays low.
        start_frame();
        spi_bits(8'($urandom), W);
        end_frame(1'b0);
        check_counts();

        // Partial word aborted by cs_n, then a clean frame.
        start_frame();
        spi_bits(8'($urandom), 5);
        end_frame(1'b1);
        check_counts();
        start_frame();
        spi_bits(8'h5A, W);
        end_frame(1'b0);
        check_counts();

        // Reset mid-frame, then a normal frame.
        write_tx(8'hA5);
        start_frame();
        spi_bits(8'hC3, 3);
        do_reset();
        check_counts();
        write_tx(8'hA5);
        start_frame();
        spi_bits(8'h3C, W);
        end_frame(1'b0);
        check_counts();

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            int nw;
            bit part;
            if ($urandom_range(1) == 1) write_tx(8'($urandom));
            start_frame();
            nw = int'($urandom_range(3, 1));
            for (int k = 0; k < nw; k++) begin
                if (!hold_full && $urandom_range(1) == 1) write_tx(8'($urandom));
                spi_bits(8'($urandom), W);
            end
            part = ($urandom_range(3) == 0);
            if (part) spi_bits(8'($urandom), int'($urandom_range(W - 1, 1)));
            end_frame(part);
            check_counts();
        end

        for (int t = 0; t < 50 && rxq.size() != 0; t++) @(negedge clk);
        chk("rx_queue_drained", 32'(rxq.size()), 32'd0);
        check_counts();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter WIDTH, default 8, frame word length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk, cs_n and mosi.
REQ-003 clock  input  1  system clock; every flop is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sclk  input  1  external SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clock.
REQ-006 cs_n  input  1  external chip select, active-low, asynchronous.
REQ-007 mosi  input  1  serial data in, MSB first.
REQ-008 miso  output  1  serial data out, MSB first.
REQ-009 miso_oe  output  1  miso output enable; high while synchronized cs_n is low.
REQ-010 tx_data  input  WIDTH  word to transmit.
REQ-011 tx_valid  input  1  tx_data is valid.
REQ-012 tx_ready  output  1  holding register is empty; a word is accepted when tx_valid and tx_ready are both high.
REQ-013 rx_data  output  WIDTH  last complete received word; holds its value until the next word completes.
REQ-014 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 tx_underrun  output  1  one-cycle pulse when a word load finds the holding register empty.
REQ-016 frame_error  output  1  one-cycle pulse when cs_n rises with a partial word (bit count neither 0 nor WIDTH).

Function
REQ-017 sclk, cs_n and mosi shall each pass through SYNC_STAGES flops, then one more flop for edge detection. rise = s_last & ~s_prev. fall = ~s_last & s_prev.
REQ-018 Timing requirement: sclk high and low times each >= 4 clock periods; no other timing is guaranteed.
REQ-019 States: IDLE (cs_n high) and ACTIVE (cs_n low).
  - IDLE -> ACTIVE on the cs_n falling edge.
  - ACTIVE -> IDLE on the cs_n rising edge.
REQ-020 IDLE -> ACTIVE entry actions:
  - bit counter cleared to 0;
  - shift_tx loaded from the holding register if it is full (holding register becomes empty);
  - otherwise shift_tx loaded with all zeros and tx_underrun pulses.
REQ-021 On each sclk rise in ACTIVE:
  - shift_rx <= {shift_rx[WIDTH-2:0], synchronized mosi};
  - bit counter increments.
REQ-022 When the bit counter reaches WIDTH (WIDTH-th rise):
  - rx_data <= the completed word;
  - rx_valid is high in the following cycle;
  - bit counter returns to 0.
REQ-023 Latency: rx_valid is high exactly SYNC_STAGES+2 clock cycles after the first clock edge that samples the final sclk high.
REQ-024 On each sclk fall in ACTIVE:
  - shift_tx shifts left by one, zero fill;
  - exception: after the WIDTH-th rise, the fall reloads shift_tx from the holding register instead, or loads zeros and pulses tx_underrun, exactly as in REQ-020.
REQ-025 miso = shift_tx[WIDTH-1] while in ACTIVE, 0 in IDLE.
REQ-026 tx_ready = holding register empty. An accept that coincides with a load is legal: the load takes the old content (or underruns), and the new word fills the register.
REQ-027 cs_n rise with bit counter in 1..WIDTH-1:
  - partial word discarded, rx_valid does not pulse;
  - frame_error pulses;
  - bit counter cleared;
  - holding register unchanged.
REQ-028 sclk edges while in IDLE are ignored. A simultaneous cs_n rise and sclk edge is processed as the cs_n rise only.
REQ-029 Back-to-back words within one frame shall need no gap; the counter wraps from WIDTH to 0.

Reset
REQ-030 While reset is low:
  - state = IDLE, all synchronizer flops = idle levels (sclk 0, cs_n 1, mosi 0);
  - shift registers, rx_data and bit counter = 0;
  - holding register empty;
  - tx_ready = 1, rx_valid = tx_underrun = frame_error = 0, miso = 0, miso_oe = 0.
REQ-031 Reset asserted mid-frame shall abort the frame with no pulses. After release, the block waits for a fresh cs_n falling edge.

Structure
REQ-032 Shared package spi_pkg holds the SPI mode constants, the default WIDTH, and the state encoding IDLE/ACTIVE.
REQ-033 One sub-module, spi_sync_edge: an N-stage synchronizer with rise/fall pulse outputs, instantiated three times.

Verification
REQ-034 Preload tx_data=0xA5, then run a frame of 8 sclk cycles (period 16 clocks) with mosi=0x3C -> rx_data=0x3C with one rx_valid pulse; miso bits 1,0,1,0,0,1,0,1 sampled on sclk rises.
REQ-035 Two back-to-back words in one frame, mosi 0x01 then 0xFF, holding register refilled with 0x80 after the first load -> two rx_valid pulses (0x01, 0xFF); miso carries 0xA5 then 0x80.
REQ-036 Frame started with no word written -> tx_underrun pulses once at the cs_n fall; miso stays 0 for all 8 bits; rx still correct.
REQ-037 cs_n raised after 5 sclk rises -> frame_error pulses once; no rx_valid; the next full frame with mosi=0x5A yields rx_data=0x5A.
REQ-038 reset pulsed low after 3 bits -> all outputs at reset values; no pulses; the next frame behaves as in REQ-034.
REQ-039 Measure latency from the final sclk rise to rx_valid -> exactly SYNC_STAGES+2 cycles.
